lc3_mem_responder: RTL and testbench

- Synthesizable memory-side responder for the LC3 microcontroller bus; it is the target that answers the CPU's rw/addr/data_in requests with data_out and complete.
- It holds a single-port word-addressed RAM and inserts a programmable number of wait states before signalling completion.
- It replaces the behavioural memory model around the CPU, so the core can be exercised against a realistic, non-zero-latency memory.

---
 rtl/lc3_mem_responder_if.sv | 20 ++
 rtl/lc3_mem_responder.sv | 111 +++++++++++
 tb/tb_lc3_mem_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_responder_if.sv
// LC3 memory bus: CPU request (mem_en/rw/addr/data_in) and responder reply (data_out/complete/busy).
interface lc3_mem_responder_if;
  logic        mem_en;
  logic        rw;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        complete;
  logic        busy;

  modport master (
    output mem_en, rw, addr, data_in,
    input  data_out, complete, busy
  );

  modport slave (
    input  mem_en, rw, addr, data_in,
    output data_out, complete, busy
  );
endinterface

// File: rtl/lc3_mem_responder.sv
// LC3 memory-side responder: single-port word RAM answering one request at a time
// after WAIT_CYC wait states, with a one-cycle complete pulse.
module lc3_mem_responder #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  lc3_mem_responder_if.slave  bus
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Request captured at acceptance; later bus activity is ignored until the next accept.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] data_out_q;
  logic              complete_q;
  logic              busy_q;
  logic              mem_we_c;
  logic              mem_re_c;

  logic [DATA_W-1:0] mem [DEPTH];

  // Upper address bits alias onto the RAM and are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[15:ADDR_W];

  // Next-state, wait counting and access strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    mem_we_c = 1'b0;
    mem_re_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_en) begin
          req_d.rw   = bus.rw;
          req_d.addr = bus.addr[ADDR_W-1:0];
          req_d.data = bus.data_in;
          cnt_d      = CNT_W'(WAIT_CYC);
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_re_c = req_q.rw;
          mem_we_c = ~req_q.rw;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request latch and registered outputs; reset drops any request in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      data_out_q <= '0;
      complete_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      complete_q <= (state_d == DONE);
      busy_q     <= (state_d != IDLE);
      if (mem_re_c) begin
        data_out_q <= mem[req_q.addr];
      end
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[req_q.addr] <= req_q.data;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.complete = complete_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: transaction-timing model plus directed literal checks.
module tb_lc3_mem_responder;

  localparam int unsigned ADDR_W = 10;
  localparam int          W      = 2;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic chk_en;

  lc3_mem_responder_if bus ();

  lc3_mem_responder #(
    .ADDR_W   (ADDR_W),
    .WAIT_CYC (W),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request accepted at edge a occupies edges a..a+W+1,
  // performs its access at edge a+W+1, and the next accept is possible at a+W+3.
  logic [15:0] m_mem [DEPTH];
  int          edge_n = 0;
  int          m_acc  = 0;
  bit          m_act  = 0;
  logic        m_rw;
  logic [15:0] m_addr, m_wdata;
  logic [15:0] m_data = 16'h0000;
  logic        m_busy = 1'b0;
  logic        m_cmpl = 1'b0;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 16'h0000;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_act  = 0;
      m_data = 16'h0000;
      m_busy = 1'b0;
      m_cmpl = 1'b0;
    end else begin
      edge_n++;
      if (m_act && (edge_n - m_acc == W + 1)) begin
        if (m_rw) m_data = m_mem[m_addr % DEPTH];
        else      m_mem[m_addr % DEPTH] = m_wdata;
      end
      if (m_act && (edge_n - m_acc >= W + 3)) m_act = 0;
      if (!m_act && bus.mem_en) begin
        m_act   = 1;
        m_acc   = edge_n;
        m_rw    = bus.rw;
        m_addr  = bus.addr;
        m_wdata = bus.data_in;
      end
      m_busy = m_act && (edge_n - m_acc <= W + 1);
      m_cmpl = m_act && (edge_n - m_acc == W + 1);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 16'(bus.busy), 16'(m_busy));
      check("complete", 16'(bus.complete), 16'(m_cmpl));
      check("data_out", bus.data_out, m_data);
    end
  end

  // Issue one request from an idle DUT (called at posedge+#1), scramble inputs during BUSY.
  task automatic do_req(input logic rw_i, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] a2, input logic [15:0] d2,
                        output logic [15:0] rd, output int lat);
    bit found;
    bus.mem_en  = 1'b1;
    bus.rw      = rw_i;
    bus.addr    = a;
    bus.data_in = d;
    @(posedge clk); #1;
    bus.mem_en  = 1'b0;
    bus.rw      = ~rw_i;
    bus.addr    = a2;
    bus.data_in = d2;
    found = 0;
    lat   = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      lat++;
      if (bus.complete) found = 1;
    end
    check("complete_seen", 16'(found), 16'd1);
    rd = bus.data_out;
    @(posedge clk); #1;
  endtask

  logic [15:0] rd;
  int          lat;
  int          pulses[$];
  int          prev_c;
  logic        dbl;

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    chk_en = 1'b0;
    reset  = 1'b0;
    bus.mem_en  = 1'b0;
    bus.rw      = 1'b0;
    bus.addr    = 16'h0000;
    bus.data_in = 16'h0000;

    // Reset held for two cycles
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_complete", 16'(bus.complete), 16'd0);
    check("rst_busy", 16'(bus.busy), 16'd0);
    check("rst_data_out", bus.data_out, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rel_busy", 16'(bus.busy), 16'd0);
    check("rel_data_out", bus.data_out, 16'h0000);
    @(posedge clk); #1;

    // Bring RAM to a known all-zero state
    for (int i = 0; i < int'(DEPTH); i++)
      do_req(1'b0, 16'(i), 16'h0000, 16'(i), 16'h0000, rd, lat);

    // Write then read with latency
    do_req(1'b0, 16'h0010, 16'hBEEF, 16'h0011, 16'h0000, rd, lat);
    check("wr_latency", 16'(lat), 16'd4);
    do_req(1'b1, 16'h0010, 16'h0000, 16'h0011, 16'h0000, rd, lat);
    check("rd_latency", 16'(lat), 16'd4);
    check("rd_beef", rd, 16'hBEEF);

    // Input changes during BUSY are ignored
    do_req(1'b0, 16'h0020, 16'h1234, 16'h0021, 16'hFFFF, rd, lat);
    do_req(1'b1, 16'h0020, 16'h0000, 16'h0000, 16'h0000, rd, lat);
    check("stable_0020", rd, 16'h1234);
    do_req(1'b1, 16'h0021, 16'h0000, 16'h0000, 16'h0000, rd, lat);
    check("stable_0021", rd, 16'h0000);

    // Address aliasing
    do_req(1'b0, 16'h0405, 16'hA5A5, 16'h0000, 16'h0000, rd, lat);
    do_req(1'b1, 16'h0005, 16'h0000, 16'h0000, 16'h0000, rd, lat);
    check("alias_0005", rd, 16'hA5A5);

    // Reset in the middle of a write drops it
    bus.mem_en = 1'b1; bus.rw = 1'b0; bus.addr = 16'h0030; bus.data_in = 16'h5555;
    @(posedge clk); #1;
    bus.mem_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rstmid_complete", 16'(bus.complete), 16'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rstmid_complete", 16'(bus.complete), 16'd0);
    end
    @(posedge clk); #1;
    do_req(1'b1, 16'h0030, 16'h0000, 16'h0000, 16'h0000, rd, lat);
    check("rstmid_read", rd, 16'h0000);
    check("rd_after_wr_data_hold", bus.data_out, 16'h0000);

    // Request presented in the same cycle reset releases
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    do_req(1'b1, 16'h0010, 16'h0000, 16'h0000, 16'h0000, rd, lat);
    check("relreq_latency", 16'(lat), 16'd4);
    check("relreq_data", rd, 16'hBEEF);

    // Back-to-back reads with mem_en held high
    bus.mem_en = 1'b1; bus.rw = 1'b1; bus.addr = 16'h0005;
    prev_c = 0;
    dbl    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.complete) begin
        pulses.push_back(i);
        if (prev_c != 0) dbl = 1'b1;
      end
      prev_c = int'(bus.complete);
    end
    bus.mem_en = 1'b0;
    check("b2b_no_double", 16'(dbl), 16'd0);
    check("b2b_pulse_cnt_ge3", 16'(pulses.size() >= 3), 16'd1);
    for (int i = 1; i < pulses.size(); i++)
      check("b2b_period", 16'(pulses[i] - pulses[i-1]), 16'(W + 3));
    repeat (8) @(posedge clk);
    #1;

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bus.mem_en  = 1'($urandom_range(0, 1));
      bus.rw      = 1'($urandom_range(0, 1));
      bus.addr    = 16'($urandom);
      bus.data_in = 16'($urandom);
      reset       = ($urandom_range(0, 99) != 0);
      @(posedge clk); #1;
    end
    reset      = 1'b1;
    bus.mem_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
